lift_scan_ctrl: RTL and testbench
=================================

// Module: lift_scan_ctrl
// PURPOSE
//  Parametrised single-car elevator controller, successor to the 8-floor Lift.
//  Latches cabin and up/down hall calls for FLOORS floors.
//  Schedules the car with SCAN: keep direction while calls lie ahead, then reverse.
//  Times floor-to-floor travel and door dwell; reports position, direction, door state and pending calls.
// PARAMETERS
//  FLOORS    8   number of floors, 2..64, floors numbered 0..FLOORS-1
//  FLOOR_W   3   width of floor index, must equal $clog2(FLOORS)
//  MOVE_CYC  10  clock cycles to travel one floor (>=1)
//  DOOR_CYC  20  clock cycles door_open_o stays high per stop (>=1)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        reset, asynchronous, active-low
//  cab_req_i    in   FLOORS   cabin buttons; bit f high in a cycle = call to floor f
//  hall_up_i    in   FLOORS   hall up buttons; bit FLOORS-1 ignored
//  hall_dn_i    in   FLOORS   hall down buttons; bit 0 ignored
//  elev_f_o     out  FLOOR_W  current car floor
//  dir_o        out  2        00 idle, 01 up, 10 down (11 never driven)
//  door_open_o  out  1        door open
//  busy_o       out  1        state != IDLE
//  pending_o    out  FLOORS   bitwise OR of latched cab/up/dn calls
// BEHAVIOUR
//  Reset (async, rst_n=0), all registers cleared:
//   - state IDLE; elev_f_o=0; dir_o=00; door_open_o=0; busy_o=0; pending_o=0.
//   - Reset mid-move or mid-door drops all calls; car position returns to floor 0.
//  Call latching, every edge:
//   - A high input bit sets its pending bit; pending bits are sticky until served.
//   - Calls for the current floor while in DOOR are not latched. They reload the door timer to DOOR_CYC instead.
//  "Ahead": any pending bit at floors > f (up) or < f (down), f = elev_f_o.
//  FSM:
//   IDLE: - call pending at f -> DOOR.
//         - else calls ahead in last direction (up after reset) -> MOVE that way.
//         - else calls on the other side -> MOVE other way.
//         - dir_o=00 while IDLE.
//   MOVE: - Timer loads MOVE_CYC on entry; elev_f_o +/-1 exactly MOVE_CYC edges after entry.
//         - On arrival at f, stop (-> DOOR) if any of:
//             cab[f] pending; hall call matching dir_o pending at f; no call ahead of f.
//         - Otherwise reload timer and continue.
//         - Floor never leaves 0..FLOORS-1.
//   DOOR: - Entry clears cab[f], up[f], dn[f] in the same edge.
//         - door_open_o high for DOOR_CYC cycles (longer if reloaded).
//         - On expiry: calls ahead -> MOVE same dir; else calls behind -> reverse dir, MOVE.
//         - Else -> IDLE.
//  Latency:
//   - Input sampled at edge t sets pending; IDLE acts at t+1.
//   - So door_open_o rises after edge t+1 for a current-floor call.
//  Simultaneous set and clear of the same bit at DOOR entry: clear wins.
//   - The call instead reloads the door timer.
//  All outputs registered; no combinational input->output paths.
// TESTING (FLOORS=8, MOVE_CYC=10, DOOR_CYC=20)
//  1. Reset, pulse cab_req_i[3] one cycle:
//     - dir_o=01; elev_f_o 1,2,3 at 10-cycle intervals.
//     - door_open_o high 20 cycles at floor 3.
//     - Then dir_o=00, busy_o=0.
//  2. Idle at 0; pulse hall_dn_i[5] and cab_req_i[2] together:
//     - Stops at 2, then continues up to 5 (no call beyond), opens, returns IDLE.
//     - pending_o=0 at end.
//  3. Going 0->6 on cab_req_i[6]; pulse hall_dn_i[3] while car is at 1:
//     - Car passes 3 without stopping, serves 6.
//     - Reverses dir_o=10, stops at 3.
//  4. Pulse hall_up_i[7] and hall_dn_i[0] only:
//     - pending_o stays 0; busy_o stays 0.
//  5. Door open at 4, pulse cab_req_i[4] at door cycle 10:
//     - door_open_o stays high 20 further cycles (30 total); pending_o[4] stays 0.
//  6. Moving at floor 3 with calls pending; drop rst_n asynchronously mid-cycle:
//     - All outputs zero before next clk edge.
//     - After release, car stays idle at 0.

Source files
------------

// File: rtl/lift_scan_ctrl.sv
// lift_scan_ctrl: single-car elevator controller with SCAN scheduling.
// Latches cabin and hall calls, moves the car one floor every MOVE_CYC
// cycles, and holds the door open for DOOR_CYC cycles at each stop.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   cab_req_i         cabin buttons, one bit per floor
//   hall_up_i         hall up buttons (top floor bit ignored)
//   hall_dn_i         hall down buttons (floor 0 bit ignored)
//   elev_f_o          current car floor
//   dir_o             00 idle, 01 up, 10 down
//   door_open_o       door open
//   busy_o            controller not idle
//   pending_o         OR of all latched calls
module lift_scan_ctrl #(
  parameter int unsigned FLOORS   = 8,
  parameter int unsigned FLOOR_W  = 3,
  parameter int unsigned MOVE_CYC = 10,
  parameter int unsigned DOOR_CYC = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  cab_req_i,
  input  logic [FLOORS-1:0]  hall_up_i,
  input  logic [FLOORS-1:0]  hall_dn_i,
  output logic [FLOOR_W-1:0] elev_f_o,
  output logic [1:0]         dir_o,
  output logic               door_open_o,
  output logic               busy_o,
  output logic [FLOORS-1:0]  pending_o
);

  localparam int unsigned TMAX = (MOVE_CYC > DOOR_CYC) ? MOVE_CYC : DOOR_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] MOVE_T    = TW'(MOVE_CYC);
  localparam logic [TW-1:0] DOOR_T    = TW'(DOOR_CYC);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;
  typedef enum logic [1:0] {DIR_NONE = 2'b00, DIR_UP = 2'b01, DIR_DN = 2'b10} dir_e;

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic               last_up_q, last_up_d;   // SCAN direction memory, up after reset
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [FLOORS-1:0]  cab_q, cab_d, up_q, up_d, dn_q, dn_d;

  logic [FLOORS-1:0]  pend_q, up_in, dn_in, clr;
  logic [FLOOR_W-1:0] nxt_floor;
  logic               ahead_fwd, ahead_rev, arr_stop, here_call;

  function automatic logic calls_ahead(input logic [FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f,
                                       input logic up);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (p[i] && (up ? (i > 32'(f)) : (i < 32'(f)))) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [FLOORS-1:0] floor_sel(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      s[i] = (i == 32'(f));
    end
    return s;
  endfunction

  assign up_in     = hall_up_i & UP_MASK;
  assign dn_in     = hall_dn_i & DN_MASK;
  assign pend_q    = cab_q | up_q | dn_q;
  assign ahead_fwd = calls_ahead(pend_q, floor_q, last_up_q);
  assign ahead_rev = calls_ahead(pend_q, floor_q, !last_up_q);
  assign nxt_floor = last_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
  // A call for the open-door floor restarts the dwell instead of latching.
  assign here_call = (state_q == S_DOOR) && ((cab_req_i | up_in | dn_in) & floor_sel(floor_q)) != '0;
  // Stop on arrival for a cabin call, a same-direction hall call, or nothing further on.
  assign arr_stop  = cab_q[nxt_floor]
                   | (last_up_q ? up_q[nxt_floor] : dn_q[nxt_floor])
                   | !calls_ahead(pend_q, nxt_floor, last_up_q);

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    last_up_d = last_up_q;
    timer_d   = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q[floor_q]) begin
          state_d = S_DOOR;
          timer_d = DOOR_T;
        end else if (ahead_fwd) begin
          state_d = S_MOVE;
          timer_d = MOVE_T;
          dir_d   = last_up_q ? DIR_UP : DIR_DN;
        end else if (ahead_rev) begin
          state_d   = S_MOVE;
          timer_d   = MOVE_T;
          last_up_d = !last_up_q;
          dir_d     = last_up_q ? DIR_DN : DIR_UP;
        end
      end
      S_MOVE: begin
        if (timer_q == TIMER_ONE) begin
          floor_d = nxt_floor;
          if (arr_stop) begin
            state_d = S_DOOR;
            timer_d = DOOR_T;
          end else begin
            timer_d = MOVE_T;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      S_DOOR: begin
        if (here_call) begin
          timer_d = DOOR_T;
        end else if (timer_q == TIMER_ONE) begin
          if (ahead_fwd) begin
            state_d = S_MOVE;
            timer_d = MOVE_T;
            dir_d   = last_up_q ? DIR_UP : DIR_DN;
          end else if (ahead_rev) begin
            state_d   = S_MOVE;
            timer_d   = MOVE_T;
            last_up_d = !last_up_q;
            dir_d     = last_up_q ? DIR_DN : DIR_UP;
          end else begin
            state_d = S_IDLE;
            dir_d   = DIR_NONE;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Whenever the door is (or becomes) open at a floor, that floor's calls
    // are cleared; this also masks new inputs there, so clear wins over set.
    clr  = (state_d == S_DOOR) ? floor_sel(floor_d) : '0;
    cab_d = (cab_q | cab_req_i) & ~clr;
    up_d  = (up_q  | up_in)     & ~clr;
    dn_d  = (dn_q  | dn_in)     & ~clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_NONE;
      last_up_q <= 1'b1;
      floor_q   <= '0;
      timer_q   <= '0;
      cab_q     <= '0;
      up_q      <= '0;
      dn_q      <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      last_up_q <= last_up_d;
      floor_q   <= floor_d;
      timer_q   <= timer_d;
      cab_q     <= cab_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
    end
  end

  assign elev_f_o    = floor_q;
  assign dir_o       = dir_q;
  assign door_open_o = (state_q == S_DOOR);
  assign busy_o      = (state_q != S_IDLE);
  assign pending_o   = pend_q;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// tb_lift_scan_ctrl: directed scoreboard bench for lift_scan_ctrl
// (FLOORS=8, MOVE_CYC=10, DOOR_CYC=20). Expected output changes, with the
// clock edge at which each must appear, are queued by the stimulus; a
// monitor compares every observed output change against the queue head.
module tb_lift_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cab_req_i = '0;
  logic [7:0] hall_up_i = '0;
  logic [7:0] hall_dn_i = '0;
  logic [2:0] elev_f_o;
  logic [1:0] dir_o;
  logic       door_open_o;
  logic       busy_o;
  logic [7:0] pending_o;

  lift_scan_ctrl #(
    .FLOORS  (8),
    .FLOOR_W (3),
    .MOVE_CYC(10),
    .DOOR_CYC(20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cab_req_i  (cab_req_i),
    .hall_up_i  (hall_up_i),
    .hall_dn_i  (hall_dn_i),
    .elev_f_o   (elev_f_o),
    .dir_o      (dir_o),
    .door_open_o(door_open_o),
    .busy_o     (busy_o),
    .pending_o  (pending_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [14:0] obs;   // {floor, dir, door, busy, pending}
  } ev_t;

  ev_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  function automatic void expect_ev(input int c, input logic [2:0] f, input logic [1:0] d,
                                    input logic dr, input logic b, input logic [7:0] p);
    ev_t e;
    e.cyc = c;
    e.obs = {f, d, dr, b, p};
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Drive a one-cycle pulse so it is sampled at posedge number e.
  task automatic pulse_at(input int e, input logic [7:0] c, input logic [7:0] u, input logic [7:0] d);
    @(negedge clk);
    while (cyc < e - 1) @(negedge clk);
    cab_req_i = c;
    hall_up_i = u;
    hall_dn_i = d;
    @(negedge clk);
    cab_req_i = '0;
    hall_up_i = '0;
    hall_dn_i = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, %0d expected events still queued, next at cyc %0d",
               name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  initial begin : main
    int t;

    fork
      begin : monitor
        logic [14:0] prev, obs;
        ev_t e;
        prev = {elev_f_o, dir_o, door_open_o, busy_o, pending_o};
        forever begin
          @(negedge clk);
          obs = {elev_f_o, dir_o, door_open_o, busy_o, pending_o};
          if (mon_en && obs !== prev) begin
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_change: at cyc %0d got f=%0d dir=%b door=%b busy=%b pend=%h, want no change",
                       cyc, obs[14:12], obs[11:10], obs[9], obs[8], obs[7:0]);
            end else begin
              e = exp_q.pop_front();
              if (e.cyc != cyc || e.obs !== obs) begin
                n_fail++;
                $display("FAIL event: got cyc=%0d f=%0d dir=%b door=%b busy=%b pend=%h, want cyc=%0d f=%0d dir=%b door=%b busy=%b pend=%h",
                         cyc, obs[14:12], obs[11:10], obs[9], obs[8], obs[7:0],
                         e.cyc, e.obs[14:12], e.obs[11:10], e.obs[9], e.obs[8], e.obs[7:0]);
              end
            end
          end
          prev = obs;
        end
      end
    join_none

    // Reset state, during and after reset.
    repeat (2) @(negedge clk);
    check("rst_floor", 32'(elev_f_o), 0);
    check("rst_dir", 32'(dir_o), 0);
    check("rst_door", 32'(door_open_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_pend", 32'(pending_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy_o), 0);
    mon_en = 1'b1;

    // 1: cab call to 3 from floor 0.
    t = cyc + 3;
    expect_ev(t,      3'd0, 2'b00, 1'b0, 1'b0, 8'h08);
    expect_ev(t + 1,  3'd0, 2'b01, 1'b0, 1'b1, 8'h08);
    expect_ev(t + 11, 3'd1, 2'b01, 1'b0, 1'b1, 8'h08);
    expect_ev(t + 21, 3'd2, 2'b01, 1'b0, 1'b1, 8'h08);
    expect_ev(t + 31, 3'd3, 2'b01, 1'b1, 1'b1, 8'h00);
    expect_ev(t + 51, 3'd3, 2'b00, 1'b0, 1'b0, 8'h00);
    pulse_at(t, 8'h08, 8'h00, 8'h00);
    wait_drain("t1_cab3", 200);

    // 2: hall down at 5 plus cab 2; stop at 2, continue to 5.
    do_reset();
    t = cyc + 3;
    expect_ev(t,      3'd0, 2'b00, 1'b0, 1'b0, 8'h24);
    expect_ev(t + 1,  3'd0, 2'b01, 1'b0, 1'b1, 8'h24);
    expect_ev(t + 11, 3'd1, 2'b01, 1'b0, 1'b1, 8'h24);
    expect_ev(t + 21, 3'd2, 2'b01, 1'b1, 1'b1, 8'h20);
    expect_ev(t + 41, 3'd2, 2'b01, 1'b0, 1'b1, 8'h20);
    expect_ev(t + 51, 3'd3, 2'b01, 1'b0, 1'b1, 8'h20);
    expect_ev(t + 61, 3'd4, 2'b01, 1'b0, 1'b1, 8'h20);
    expect_ev(t + 71, 3'd5, 2'b01, 1'b1, 1'b1, 8'h00);
    expect_ev(t + 91, 3'd5, 2'b00, 1'b0, 1'b0, 8'h00);
    pulse_at(t, 8'h04, 8'h00, 8'h20);
    wait_drain("t2_dn5_cab2", 300);
    check("t2_pend_end", 32'(pending_o), 0);

    // 3: heading to 6, hall down at 3 latched while at 1; passed, served on reversal.
    do_reset();
    t = cyc + 3;
    expect_ev(t,       3'd0, 2'b00, 1'b0, 1'b0, 8'h40);
    expect_ev(t + 1,   3'd0, 2'b01, 1'b0, 1'b1, 8'h40);
    expect_ev(t + 11,  3'd1, 2'b01, 1'b0, 1'b1, 8'h40);
    expect_ev(t + 15,  3'd1, 2'b01, 1'b0, 1'b1, 8'h48);
    expect_ev(t + 21,  3'd2, 2'b01, 1'b0, 1'b1, 8'h48);
    expect_ev(t + 31,  3'd3, 2'b01, 1'b0, 1'b1, 8'h48);
    expect_ev(t + 41,  3'd4, 2'b01, 1'b0, 1'b1, 8'h48);
    expect_ev(t + 51,  3'd5, 2'b01, 1'b0, 1'b1, 8'h48);
    expect_ev(t + 61,  3'd6, 2'b01, 1'b1, 1'b1, 8'h08);
    expect_ev(t + 81,  3'd6, 2'b10, 1'b0, 1'b1, 8'h08);
    expect_ev(t + 91,  3'd5, 2'b10, 1'b0, 1'b1, 8'h08);
    expect_ev(t + 101, 3'd4, 2'b10, 1'b0, 1'b1, 8'h08);
    expect_ev(t + 111, 3'd3, 2'b10, 1'b1, 1'b1, 8'h00);
    expect_ev(t + 131, 3'd3, 2'b00, 1'b0, 1'b0, 8'h00);
    pulse_at(t, 8'h40, 8'h00, 8'h00);
    pulse_at(t + 15, 8'h00, 8'h00, 8'h08);
    wait_drain("t3_pass_reverse", 400);

    // 4: ignored hall bits (up at top, down at bottom); no output change expected.
    t = cyc + 3;
    pulse_at(t, 8'h00, 8'h80, 8'h01);
    repeat (5) @(negedge clk);
    check("t4_pend", 32'(pending_o), 0);
    check("t4_busy", 32'(busy_o), 0);

    // 5: from idle at 3 (last dir down) go up to 4; cab 4 at door cycle 10 extends dwell to 30.
    t = cyc + 3;
    expect_ev(t,      3'd3, 2'b00, 1'b0, 1'b0, 8'h10);
    expect_ev(t + 1,  3'd3, 2'b01, 1'b0, 1'b1, 8'h10);
    expect_ev(t + 11, 3'd4, 2'b01, 1'b1, 1'b1, 8'h00);
    expect_ev(t + 41, 3'd4, 2'b00, 1'b0, 1'b0, 8'h00);
    pulse_at(t, 8'h10, 8'h00, 8'h00);
    pulse_at(t + 21, 8'h10, 8'h00, 8'h00);
    wait_drain("t5_door_reload", 200);

    // 6: async reset while moving at floor 3.
    do_reset();
    mon_en = 1'b0;
    t = cyc + 3;
    pulse_at(t, 8'h80, 8'h00, 8'h00);
    while (cyc < t + 35) @(negedge clk);
    check("t6_pre_floor", 32'(elev_f_o), 3);
    check("t6_pre_busy", 32'(busy_o), 1);
    check("t6_pre_dir", 32'(dir_o), 1);
    check("t6_pre_pend", 32'(pending_o), 32'h80);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_floor", 32'(elev_f_o), 0);
    check("t6_async_dir", 32'(dir_o), 0);
    check("t6_async_door", 32'(door_open_o), 0);
    check("t6_async_busy", 32'(busy_o), 0);
    check("t6_async_pend", 32'(pending_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_after_floor", 32'(elev_f_o), 0);
    check("t6_after_busy", 32'(busy_o), 0);
    check("t6_after_dir", 32'(dir_o), 0);
    check("t6_after_pend", 32'(pending_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
